// File: rtl/hifigan_act_pkg.sv
// Shared definitions for the HiFi-GAN activation units: mode encodings and
// the default Q15 leaky slope.
package hifigan_act_pkg;

  typedef enum logic [1:0] {
    ACT_LEAKY  = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_BYPASS = 2'd2
  } act_mode_e;

  // 0.1 in Q15
  localparam int ACT_DEFAULT_SLOPE = 3277;

endpackage

// File: rtl/leaky_relu_lane.sv
// Per-lane combinational datapath: the slope product feeding stage 1, and the
// round/saturate/select that turns a stage-1 product into the stage-2 result.
module leaky_relu_lane
  import hifigan_act_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLOPE_W = 16,
  parameter int FRAC_W  = 15
) (
  input  logic [DATA_W-1:0]         x,
  input  logic [SLOPE_W-1:0]        slope,
  output logic [DATA_W+SLOPE_W-1:0] prod,
  input  logic [DATA_W-1:0]         x_r,
  input  logic                      neg_r,
  input  logic [1:0]                mode_r,
  input  logic [DATA_W+SLOPE_W-1:0] prod_r,
  output logic [DATA_W-1:0]         y
);

  localparam int PROD_W = DATA_W + SLOPE_W;
  localparam logic [PROD_W:0] RND = (PROD_W+1)'(1) << (FRAC_W - 1);

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] slope_ext;
  logic [PROD_W:0]          sum;
  logic [PROD_W:0]          shifted;
  logic                     fits;
  logic [DATA_W-1:0]        scaled;

  assign x_ext     = {{SLOPE_W{x[DATA_W-1]}}, x};
  assign slope_ext = {{DATA_W{slope[SLOPE_W-1]}}, slope};
  assign prod      = x_ext * slope_ext;

  // One guard bit above the product keeps the rounding add from wrapping.
  assign sum     = {prod_r[PROD_W-1], prod_r} + RND;
  assign shifted = $signed(sum) >>> FRAC_W;
  assign fits    = (&shifted[PROD_W:DATA_W-1]) | ~(|shifted[PROD_W:DATA_W-1]);
  assign scaled  = fits ? shifted[DATA_W-1:0] :
                   (shifted[PROD_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}});

  always_comb begin
    y = x_r;
    if (neg_r) begin
      case (mode_r)
        ACT_LEAKY: y = scaled;
        ACT_RELU:  y = '0;
        default:   y = x_r;
      endcase
    end
  end

endmodule

// File: rtl/leaky_relu_stream.sv
// Streaming multi-lane Leaky ReLU: two-stage pipeline with a single global
// advance enable, so a stalled output freezes the whole pipe.
module leaky_relu_stream
  import hifigan_act_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 15,
  parameter int SLOPE_W   = 16,
  parameter int LANES     = 4,
  parameter int SLOPE_RST = ACT_DEFAULT_SLOPE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_mode,
  input  logic [SLOPE_W-1:0]        cfg_slope,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*DATA_W-1:0]   s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*DATA_W-1:0]   m_data,
  output logic                      m_last
);

  localparam int PROD_W = DATA_W + SLOPE_W;
  localparam int BEAT_W = LANES * DATA_W;

  logic                    en;
  logic [1:0]              mode_q, mode_d;
  logic [SLOPE_W-1:0]      slope_q, slope_d;

  logic                    s1_valid_q, s1_valid_d;
  logic [BEAT_W-1:0]       s1_data_q, s1_data_d;
  logic [LANES-1:0]        s1_neg_q, s1_neg_d;
  logic [1:0]              s1_mode_q, s1_mode_d;
  logic [LANES*PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic                    s1_last_q, s1_last_d;

  logic                    m_valid_q, m_valid_d;
  logic [BEAT_W-1:0]       m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;

  logic [LANES*PROD_W-1:0] prod_c;
  logic [BEAT_W-1:0]       y_c;
  logic [LANES-1:0]        neg_c;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign neg_c[i] = s_data[i*DATA_W + DATA_W - 1];

    leaky_relu_lane #(
      .DATA_W (DATA_W),
      .SLOPE_W(SLOPE_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .x     (s_data[i*DATA_W +: DATA_W]),
      .slope (slope_q),
      .prod  (prod_c[i*PROD_W +: PROD_W]),
      .x_r   (s1_data_q[i*DATA_W +: DATA_W]),
      .neg_r (s1_neg_q[i]),
      .mode_r(s1_mode_q),
      .prod_r(s1_prod_q[i*PROD_W +: PROD_W]),
      .y     (y_c[i*DATA_W +: DATA_W])
    );
  end

  assign en      = !m_valid_q || m_ready;
  assign s_ready = en;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  // Beats capture the config registers, not cfg_*, so a same-cycle write
  // only reaches the beats accepted afterwards.
  always_comb begin
    mode_d     = mode_q;
    slope_d    = slope_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_neg_d   = s1_neg_q;
    s1_mode_d  = s1_mode_q;
    s1_prod_d  = s1_prod_q;
    s1_last_d  = s1_last_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;

    if (cfg_we) begin
      mode_d  = cfg_mode;
      slope_d = cfg_slope;
    end

    if (en) begin
      s1_valid_d = s_valid;
      if (s_valid) begin
        s1_data_d = s_data;
        s1_neg_d  = neg_c;
        s1_mode_d = mode_q;
        s1_prod_d = prod_c;
        s1_last_d = s_last;
      end
      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        m_data_d = y_c;
        m_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= 2'(ACT_LEAKY);
      slope_q    <= SLOPE_W'(SLOPE_RST);
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_neg_q   <= '0;
      s1_mode_q  <= '0;
      s1_prod_q  <= '0;
      s1_last_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      slope_q    <= slope_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_neg_q   <= s1_neg_d;
      s1_mode_q  <= s1_mode_d;
      s1_prod_q  <= s1_prod_d;
      s1_last_q  <= s1_last_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
    end
  end

endmodule

// File: tb/tb_leaky_relu_stream.sv
// Self-checking bench for leaky_relu_stream: directed vectors plus randomized
// streams scored against an arithmetic Leaky ReLU model.
module tb_leaky_relu_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_slope;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  tb_mode;
  logic [15:0] tb_slope;
  logic [64:0] exp_q[$];

  logic        obs_valid, obs_last, obs_sready;
  logic [63:0] obs_data;

  always #5 clk = ~clk;

  leaky_relu_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_mode (cfg_mode),
    .cfg_slope(cfg_slope),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  function automatic int ref_lane(input int x, input int slope, input int mode);
    longint r, y;
    if (x >= 0 || mode >= 2) return x;
    if (mode == 1) return 0;
    r = longint'(x) * longint'(slope) + 64'sd16384;
    if (r >= 0) y = r / 32768;
    else        y = -((-r + 32767) / 32768);
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  function automatic logic [63:0] ref_beat(input logic [63:0] d, input logic [1:0] md,
                                           input logic [15:0] sl);
    logic [63:0] r;
    int x;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = int'($signed(d[i*16 +: 16]));
      r[i*16 +: 16] = 16'(ref_lane(x, int'($signed(sl)), int'(md)));
    end
    return r;
  endfunction

  // One cycle: drive at negedge, sample shortly after, and record what the
  // coming posedge will accept using the bench's own view of the config.
  task automatic step(input logic v, input logic [63:0] d, input logic l, input logic rdy,
                      input logic we, input logic [1:0] md, input logic [15:0] sl);
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; m_ready = rdy;
    cfg_we = we; cfg_mode = md; cfg_slope = sl;
    #1;
    obs_valid = m_valid; obs_data = m_data; obs_last = m_last; obs_sready = s_ready;
    if (v && s_ready) exp_q.push_back({l, ref_beat(d, tb_mode, tb_slope)});
    if (we) begin
      tb_mode = md;
      tb_slope = sl;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
    n_tests++;
    if (m_data !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_m_data: got %h want 0", m_data); end
    n_tests++;
    if (m_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_last: got %b want 0", m_last); end
    n_tests++;
    if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_s_ready: got %b want 1", s_ready); end
    rst_n = 1'b1;
    tb_mode = 2'd0;
    tb_slope = 16'd3277;
  endtask

  task automatic test_vectors();
    logic [1:0]  vm[6];
    logic [15:0] vs[6];
    logic [63:0] vx[6], vy[6];
    int lat;
    vm = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    vs = '{16'd3277, 16'd32767, 16'h8000, 16'd100, 16'd100, 16'd100};
    vx[0] = {16'hC000, 16'h7FFF, 16'h2000, 16'h0000};
    vy[0] = {16'hF99A, 16'h7FFF, 16'h2000, 16'h0000};
    vx[1] = {4{16'h8000}};
    vy[1] = {4{16'h8001}};
    vx[2] = {4{16'h8000}};
    vy[2] = {4{16'h7FFF}};
    vx[3] = {16'h0000, 16'hFFFF, 16'h0064, 16'hE000};
    vy[3] = {16'h0000, 16'h0000, 16'h0064, 16'h0000};
    vx[4] = {16'h8000, 16'h7FFF, 16'hFFFF, 16'hE000};
    vy[4] = vx[4];
    vx[5] = vx[4];
    vy[5] = vx[4];
    for (int i = 0; i < 6; i++) begin
      // Vector 0 relies on the reset-default slope and mode.
      if (i > 0) step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, vm[i], vs[i]);
      step(1'b1, vx[i], 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
      n_tests++;
      if (obs_sready !== 1'b1) begin n_fail++; $display("[TB] FAIL vec%0d_s_ready: got %b want 1", i, obs_sready); end
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        if (obs_valid === 1'b1) begin
          lat = k;
          break;
        end
      end
      n_tests++;
      if (lat != 2) begin n_fail++; $display("[TB] FAIL vec%0d_latency: got %0d want 2", i, lat); end
      n_tests++;
      if (obs_data !== vy[i]) begin n_fail++; $display("[TB] FAIL vec%0d_data: got %h want %h", i, obs_data, vy[i]); end
      n_tests++;
      if (obs_last !== 1'b0) begin n_fail++; $display("[TB] FAIL vec%0d_last: got %b want 0", i, obs_last); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int n_out;
    logic [63:0] d;
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd3277);
    exp_q.delete();
    n_out = 0;
    for (int i = 0; i < 66; i++) begin
      d = {$urandom, $urandom};
      step(i < 64, d, i == 63, 1'b1, 1'b0, 2'd0, 16'd0);
      n_tests++;
      if (obs_valid !== (i >= 2 && i <= 65)) begin
        n_fail++;
        $display("[TB] FAIL b2b_valid_cycle%0d: got %b want %b", i, obs_valid, (i >= 2 && i <= 65));
      end
      if (obs_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL b2b_spurious: got %h want none", obs_data);
        end else begin
          if ({obs_last, obs_data} !== exp_q[0]) begin
            n_fail++; $display("[TB] FAIL b2b_beat%0d: got %b/%h want %b/%h", n_out, obs_last, obs_data, exp_q[0][64], exp_q[0][63:0]);
          end
          void'(exp_q.pop_front());
        end
        n_out++;
      end
    end
    n_tests++;
    if (n_out != 64 || exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL b2b_count: got %0d left %0d want 64 left 0", n_out, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n_in, n_out;
    logic [63:0] d;
    logic l, rdy, we, prev_stall;
    exp_q.delete();
    n_in = 0; n_out = 0; prev_stall = 1'b0;
    d = {$urandom, $urandom};
    l = 1'($urandom_range(0, 1));
    for (int i = 0; i < 170; i++) begin
      rdy = (i >= 150) ? 1'b1 : 1'($urandom_range(0, 1));
      we = (i < 150) && ($urandom_range(0, 7) == 0);
      step(i < 150, d, l, rdy, we, 2'($urandom_range(0, 3)), 16'($urandom));
      if (i < 150 && obs_sready) begin
        n_in++;
        d = {$urandom, $urandom};
        l = 1'($urandom_range(0, 1));
      end
      if (prev_stall) begin
        n_tests++;
        if (obs_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_valid%0d: got %b want 1", i, obs_valid); end
      end
      if (obs_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL bp_spurious: got %h want none", obs_data);
        end else if ({obs_last, obs_data} !== exp_q[0]) begin
          n_fail++; $display("[TB] FAIL bp_beat%0d: got %b/%h want %b/%h", n_out, obs_last, obs_data, exp_q[0][64], exp_q[0][63:0]);
        end
        if (rdy && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
      prev_stall = obs_valid && !rdy;
    end
    n_tests++;
    if (n_out != n_in || exp_q.size() != 0 || n_in == 0) begin
      n_fail++; $display("[TB] FAIL bp_count: got %0d out left %0d want %0d out left 0", n_out, exp_q.size(), n_in);
    end
  endtask

  task automatic test_cfg_in_flight();
    logic [63:0] xneg, want[3];
    int got;
    logic v, we;
    xneg = {4{16'hC000}};
    want = '{{4{16'hF99A}}, {4{16'hF99A}}, {4{16'hE000}}};
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd3277);
    got = 0;
    for (int i = 0; i < 12; i++) begin
      v  = (i == 0 || i == 1 || i == 3);
      we = (i == 2);
      step(v, xneg, 1'b0, 1'b1, we, 2'd0, we ? 16'd16384 : 16'd0);
      if (obs_valid === 1'b1) begin
        n_tests++;
        if (got >= 3) begin
          n_fail++; $display("[TB] FAIL cfg_extra: got %h want none", obs_data);
        end else if (obs_data !== want[got]) begin
          n_fail++; $display("[TB] FAIL cfg_beat%0d: got %h want %h", got, obs_data, want[got]);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 3) begin n_fail++; $display("[TB] FAIL cfg_count: got %0d want 3", got); end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic [63:0] xneg;
    int lat;
    xneg = {4{16'hC000}};
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 2'd1, 16'd100);
    step(1'b1, xneg, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
    step(1'b1, xneg, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tb_mode = 2'd0; tb_slope = 16'd3277;
    exp_q.delete();
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valid: got %b want 0", m_valid); end
    n_tests++;
    if (m_data !== 64'd0) begin n_fail++; $display("[TB] FAIL mid_rst_data: got %h want 0", m_data); end
    n_tests++;
    if (m_last !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_last: got %b want 0", m_last); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
      n_tests++;
      if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_stale%0d: got %b want 0", i, obs_valid); end
    end
    step(1'b1, xneg, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
      if (obs_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_tests++;
    if (lat != 2) begin n_fail++; $display("[TB] FAIL mid_rst_latency: got %0d want 2", lat); end
    n_tests++;
    if (obs_data !== {4{16'hF99A}}) begin
      n_fail++; $display("[TB] FAIL mid_rst_slope: got %h want %h", obs_data, {4{16'hF99A}});
    end
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_mode = 2'd0; cfg_slope = 16'd0;
    s_valid = 1'b0; s_data = 64'd0; s_last = 1'b0; m_ready = 1'b1;
    tb_mode = 2'd0; tb_slope = 16'd3277;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_cfg_in_flight();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/leaky_relu_stream.md
# leaky_relu_stream

Streaming, multi-lane Leaky ReLU activation unit for the HiFi-GAN datapath, replacing the single-sample combinational Q15 Leaky ReLU in the activation unit. It accepts LANES signed fixed-point samples per beat over a valid/ready stream. It applies a runtime-programmable slope to negative samples, with round-half-up and saturation, through a 2-stage pipeline. It sits between the convolution/upsample output and the next MRF/ResBlock input.

## Interface
- DATA_W, 16, sample width (signed two's complement)
- FRAC_W, 15, fractional bits of the slope (slope is signed Q(SLOPE_W-FRAC_W).FRAC_W)
- SLOPE_W, 16, slope register width
- LANES, 4, samples per beat
- SLOPE_RST, 3277, slope reset value (0.1 in Q15)
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset; synchronous, active-low
- cfg_we  in  1  config write strobe
- cfg_mode  in  2  0 leaky, 1 plain ReLU, 2/3 bypass
- cfg_slope  in  SLOPE_W  signed slope for negative samples
- s_valid  in  1  input beat valid
- s_ready  out  1  unit can accept a beat
- s_data  in  LANES*DATA_W  packed samples; lane i at bits [i*DATA_W +: DATA_W]
- s_last  in  1  end-of-frame marker, passed through
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_data  out  LANES*DATA_W  packed results
- m_last  out  1  delayed s_last

## Operation
- Config registers mode_r (reset 0) and slope_r (reset SLOPE_RST) are written when cfg_we=1. They are visible from the next cycle.
- Each accepted beat captures mode_r/slope_r into stage 1 alongside its data. Beats already in flight keep the config they entered with. A cfg_we in the same cycle as acceptance does not affect that beat.
- Per lane, for input x:
  - x >= 0: y = x in all modes.
  - x < 0, mode 0: p = x*slope (DATA_W+SLOPE_W bits, signed). y = sat((p + 2^(FRAC_W-1)) >>> FRAC_W), an arithmetic shift (round half toward +inf).
  - x < 0, mode 1: y = 0.
  - Mode 2/3: y = x unchanged.
- sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. It is only reachable with negative or >=1.0 slopes, e.g. x=-32768 with slope=-32768 gives 32767.
- Stage 1 registers the data, sign bits, config, product and last. Stage 2 registers the rounded, saturated result.

## Timing
- Latency: 2 cycles from acceptance (s_valid&&s_ready) to m_valid, with no stall.
- Global advance enable is en = !m_valid || m_ready. Both stages shift when en=1, and s_ready = en.
  - Throughput is 1 beat/cycle while m_ready stays high.
  - With m_ready=0 and m_valid=1 the whole pipe freezes, including stage-1 bubbles.
- m_data and m_last must hold stable while m_valid && !m_ready.
- Reset (rst_n=0 at a clock edge):
  - Stage valids are cleared and m_valid=0. m_data=0 and m_last=0.
  - mode_r=0 and slope_r=SLOPE_RST.
  - s_ready=1 from the first cycle after reset.
- Reset mid-stream discards all in-flight beats; nothing is emitted afterwards for them.
- s_valid=0 cycles insert bubbles; m_valid then drops for the same number of cycles.

## Structure
- Shared package/header `hifigan_act_pkg`: mode encodings (ACT_LEAKY=0, ACT_RELU=1, ACT_BYPASS=2) and the default Q15 slope constant 3277.
- Sub-module `leaky_relu_lane`, instantiated LANES times via generate. It is purely combinational and holds the per-lane multiply/select, round and saturate. Stage registers and handshake live in the top.

## Test plan
- Mode 0, slope 3277, lanes {0, 8192, 32767, -16384} -> {0, 8192, 32767, -1638} after 2 cycles.
- Mode 0, slope 32767, x=-32768 -> -32767. Then slope -32768, x=-32768 -> 32767 (saturated). Mode 1, x=-8192 -> 0. Mode 2, x=-8192 -> -8192.
- Continuous 64-beat stream with m_ready=1 -> one output per cycle, in order, with m_last on beat 64 only.
- Random m_ready toggling with s_valid held -> no loss or duplication. m_data stays stable while stalled. Output count equals input count.
- cfg_we changes the slope 3277->16384 while 2 beats are in flight with x=-16384. In-flight beats output -1638; the next accepted beat outputs -8192.
- rst_n=0 for 1 cycle with 2 beats in flight -> m_valid=0 next cycle, m_data=0, no stale beats emitted, and slope returns to 3277.
